// File: rtl/vc_test_pkg.sv
// Shared types and constants for the multi-channel test sink: channel FSM
// states and the 16-bit Galois LFSR used to generate random ready delays.
package vc_test_pkg;

    localparam int          LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_WAIT,
        ST_DONE
    } chan_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Index width that never collapses to zero bits for single-entry cases.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_test_sink_chan.sv
// One sink channel: expected-message memory, random ready-delay LFSR,
// IDLE/DELAY/WAIT/DONE handshake FSM and the message comparator.
module vc_test_sink_chan
    import vc_test_pkg::*;
#(
    parameter int          p_msg_nbits  = 8,
    parameter int          p_addr_nbits = 4,
    parameter logic [15:0] p_seed       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              max_delay,
    input  logic [p_addr_nbits:0]   num_msgs,
    input  logic                    load_en,
    input  logic [p_addr_nbits-1:0] load_addr,
    input  logic [p_msg_nbits-1:0]  load_data,
    input  logic                    run,
    input  logic                    rearm,
    input  logic                    val,
    input  logic [p_msg_nbits-1:0]  msg,
    output logic                    rdy,
    output logic                    is_idle,
    output logic                    is_done,
    output logic                    mismatch,
    output logic [p_addr_nbits-1:0] idx
);

    chan_state_e               state, state_next;
    logic [7:0]                d, d_next;
    logic [p_addr_nbits-1:0]   idx_next;
    logic [LFSR_W-1:0]         lfsr;
    logic [p_msg_nbits-1:0]    mem [2**p_addr_nbits];
    logic [8:0]                draw_w;
    logic [7:0]                draw;
    logic                      last;

    // Delay candidate is always in [0, max_delay]; the divisor is never zero.
    assign draw_w   = {1'b0, lfsr[7:0]} % ({1'b0, max_delay} + 9'd1);
    assign draw     = draw_w[7:0];
    assign last     = (({1'b0, idx}) + (p_addr_nbits+1)'(1)) == num_msgs;

    assign rdy      = (state == ST_WAIT);
    assign is_idle  = (state == ST_IDLE);
    assign is_done  = (state == ST_DONE);
    assign mismatch = rdy && val && (msg != mem[idx]);

    // Expected-message storage, written only through the gated load port.
    // NOTE: no reset on the memory -- contents must survive reset so a run can
    // be repeated without reloading, and it keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    // State, delay counter, message index and free-running LFSR.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            d     <= '0;
            idx   <= '0;
            lfsr  <= p_seed;
        end else begin
            state <= state_next;
            d     <= d_next;
            idx   <= idx_next;
            lfsr  <= lfsr_next(lfsr);
        end
    end

    // Next-state logic for the handshake FSM.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        d_next     = d;
        idx_next   = idx;
        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    idx_next = '0;
                    if (num_msgs == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        d_next     = draw;
                        state_next = (draw == 8'd0) ? ST_WAIT : ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                d_next = d - 8'd1;
                if (d <= 8'd1) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (val) begin
                    idx_next = idx + p_addr_nbits'(1);
                    if (last) begin
                        state_next = ST_DONE;
                    end else begin
                        d_next     = draw;
                        state_next = (draw == 8'd0) ? ST_WAIT : ST_DELAY;
                    end
                end
            end
            ST_DONE: begin
                if (rearm) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/vc_test_multi_chan_sink.sv
// Multi-channel test sink: one vc_test_sink_chan per channel, plus the shared
// start/load gating, done reduction, first-error capture and error counter.
module vc_test_multi_chan_sink
    import vc_test_pkg::*;
#(
    parameter int          p_msg_nbits = 8,
    parameter int          p_nchan     = 2,
    parameter int          p_max_msgs  = 16,
    parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [7:0]                             max_delay,
    input  logic [clog2_min1(p_max_msgs):0]        num_msgs,
    input  logic                                   load_en,
    input  logic [clog2_min1(p_nchan)-1:0]         load_chan,
    input  logic [clog2_min1(p_max_msgs)-1:0]      load_addr,
    input  logic [p_msg_nbits-1:0]                 load_data,
    input  logic                                   start,
    input  logic [p_nchan-1:0]                     val,
    output logic [p_nchan-1:0]                     rdy,
    input  logic [p_nchan*p_msg_nbits-1:0]         msg,
    output logic                                   done,
    output logic                                   error,
    output logic [clog2_min1(p_nchan)-1:0]         err_chan,
    output logic [clog2_min1(p_max_msgs)-1:0]      err_idx,
    output logic [15:0]                            err_count
);

    localparam int AW = clog2_min1(p_max_msgs);
    localparam int CW = clog2_min1(p_nchan);

    logic [p_nchan-1:0] chan_idle, chan_done, mismatch;
    logic [AW-1:0]      chan_idx [p_nchan];
    logic               all_idle, run, rearm;
    logic               first_hit;
    logic [CW-1:0]      first_chan;
    logic [AW-1:0]      first_idx;
    logic [15:0]        mm_count;
    logic [16:0]        count_sum;
    logic [15:0]        count_next;

    assign all_idle = &chan_idle;
    assign done     = &chan_done;
    // A new run starts only from all-IDLE; DONE channels rearm only once all are done.
    assign run      = start && all_idle;
    assign rearm    = start && done;

    for (genvar c = 0; c < p_nchan; c++) begin : g_chan
        vc_test_sink_chan #(
            .p_msg_nbits  (p_msg_nbits),
            .p_addr_nbits (AW),
            .p_seed       (p_lfsr_seed ^ 16'(c))
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .max_delay (max_delay),
            .num_msgs  (num_msgs),
            .load_en   (load_en && all_idle && (load_chan == CW'(c))),
            .load_addr (load_addr),
            .load_data (load_data),
            .run       (run),
            .rearm     (rearm),
            .val       (val[c]),
            .msg       (msg[c*p_msg_nbits +: p_msg_nbits]),
            .rdy       (rdy[c]),
            .is_idle   (chan_idle[c]),
            .is_done   (chan_done[c]),
            .mismatch  (mismatch[c]),
            .idx       (chan_idx[c])
        );
    end

    // Pick the lowest mismatching channel and count all mismatches this cycle.
    always_comb begin
        first_hit  = 1'b0;
        first_chan = '0;
        first_idx  = '0;
        mm_count   = '0;
        for (int c = p_nchan - 1; c >= 0; c--) begin
            if (mismatch[c]) begin
                first_hit  = 1'b1;
                first_chan = CW'(c);
                first_idx  = chan_idx[c];
            end
            mm_count = mm_count + 16'(mismatch[c]);
        end
        count_sum  = {1'b0, err_count} + {1'b0, mm_count};
        count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    // Sticky first-error capture and saturating mismatch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error     <= 1'b0;
            err_chan  <= '0;
            err_idx   <= '0;
            err_count <= '0;
        end else begin
            if (first_hit && !error) begin
                error    <= 1'b1;
                err_chan <= first_chan;
                err_idx  <= first_idx;
            end
            err_count <= count_next;
        end
    end

endmodule

// File: tb/tb_vc_test_multi_chan_sink.sv
// Self-checking bench for vc_test_multi_chan_sink: table of directed runs,
// hand-written corner sequences, and a behavioural ready/done model.
module tb_vc_test_multi_chan_sink;

    localparam int          NC   = 2;
    localparam int          W    = 8;
    localparam int          AW   = 4;
    localparam int          NW   = 5;
    localparam int          TR   = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_IDLE = 0, M_DELAY = 1, M_WAIT = 2, M_DONE = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      max_delay;
    logic [NW-1:0]   num_msgs;
    logic            load_en;
    logic [0:0]      load_chan;
    logic [AW-1:0]   load_addr;
    logic [W-1:0]    load_data;
    logic            start;
    logic [NC-1:0]   val;
    logic [NC-1:0]   rdy;
    logic [NC*W-1:0] msg;
    logic            done;
    logic            error;
    logic [0:0]      err_chan;
    logic [AW-1:0]   err_idx;
    logic [15:0]     err_count;

    always #5 clk = ~clk;

    vc_test_multi_chan_sink dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .num_msgs  (num_msgs),
        .load_en   (load_en),
        .load_chan (load_chan),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done),
        .error     (error),
        .err_chan  (err_chan),
        .err_idx   (err_idx),
        .err_count (err_count)
    );

    typedef struct {
        string      name;
        logic [7:0] md;
        int         n;
        bit         full;
        bit         poke;
        logic [1:0] cmask;
        int         cidx;
        int         e_err;
        int         e_chan;
        int         e_idx;
        int         e_cnt;
        int         e_lat;
    } vec_t;

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            model_bad = 0;
    int            sent [NC];
    logic [NC-1:0] trace_now [TR];
    logic [NC-1:0] trace_ref [TR];
    vec_t          vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural ready/done model ----------------
    int            m_st [NC];
    int            m_d [NC];
    int            m_idx [NC];
    logic [15:0]   m_lfsr [NC];
    logic [NC-1:0] m_rdy;
    logic          m_all_idle, m_done;

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int m_draw(input logic [15:0] s, input logic [7:0] md);
        return int'(s[7:0]) % (int'(md) + 1);
    endfunction

    always_comb begin
        m_all_idle = 1'b1;
        m_done     = 1'b1;
        m_rdy      = '0;
        for (int c = 0; c < NC; c++) begin
            m_rdy[c] = (m_st[c] == M_WAIT);
            if (m_st[c] != M_IDLE) m_all_idle = 1'b0;
            if (m_st[c] != M_DONE) m_done = 1'b0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NC; c++) begin
                m_st[c]   <= M_IDLE;
                m_d[c]    <= 0;
                m_idx[c]  <= 0;
                m_lfsr[c] <= SEED ^ 16'(c);
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                m_lfsr[c] <= m_step(m_lfsr[c]);
                case (m_st[c])
                    M_IDLE: if (start && m_all_idle) begin
                        m_idx[c] <= 0;
                        if (num_msgs == 0) m_st[c] <= M_DONE;
                        else begin
                            m_d[c]  <= m_draw(m_lfsr[c], max_delay);
                            m_st[c] <= (m_draw(m_lfsr[c], max_delay) == 0) ? M_WAIT : M_DELAY;
                        end
                    end
                    M_DELAY: begin
                        m_d[c] <= m_d[c] - 1;
                        if (m_d[c] <= 1) m_st[c] <= M_WAIT;
                    end
                    M_WAIT: if (val[c]) begin
                        m_idx[c] <= m_idx[c] + 1;
                        if (m_idx[c] + 1 == int'(num_msgs)) m_st[c] <= M_DONE;
                        else begin
                            m_d[c]  <= m_draw(m_lfsr[c], max_delay);
                            m_st[c] <= (m_draw(m_lfsr[c], max_delay) == 0) ? M_WAIT : M_DELAY;
                        end
                    end
                    M_DONE: if (start && m_done) m_st[c] <= M_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && (rdy !== m_rdy || done !== m_done)) model_bad++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] src_data(input int c, input int i, input vec_t v);
        logic [W-1:0] e;
        e = W'(i + c);
        if (v.cmask[c] && i == v.cidx) e = 8'hFF;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        start   = 1'b0;
        val     = '0;
        load_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_mem();
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                load_en   = 1'b1;
                load_chan = 1'(c);
                load_addr = AW'(i);
                load_data = W'(i + c);
            end
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run_core(input vec_t v, input int stray_at, input int abort_at,
                            output int done_cyc, output int first, output bit rdy_gap);
        bit pend [NC];
        done_cyc = -1;
        first    = -1;
        rdy_gap  = 1'b0;
        for (int c = 0; c < NC; c++) begin
            sent[c] = 0;
            pend[c] = 1'b0;
        end
        for (int k = 0; k < TR; k++) trace_now[k] = '0;
        max_delay = v.md;
        num_msgs  = NW'(v.n);
        @(negedge clk);
        start = 1'b1;
        val   = '0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            load_en = 1'b0;
            if (cyc == abort_at) begin
                #1 reset = 1'b0;
                val = '0;
                #1;
                check("async_reset_rdy", rdy, 0);
                check("async_reset_done", done, 0);
                return;
            end
            for (int c = 0; c < NC; c++) if (pend[c]) sent[c]++;
            if (cyc < TR) trace_now[cyc] = rdy;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (first >= 0 && rdy != '1) rdy_gap = 1'b1;
            if (cyc == stray_at) start = 1'b1;
            if (v.poke && cyc == 1) begin
                load_en   = 1'b1;
                load_chan = 1'b0;
                load_addr = 4'd3;
                load_data = 8'h55;
            end
            for (int c = 0; c < NC; c++) begin
                val[c] = (sent[c] < v.n) && (v.full || ($urandom_range(0, 1) == 1));
                msg[c*W +: W] = src_data(c, sent[c], v);
                pend[c] = val[c] && rdy[c];
                if (pend[c] && first < 0) first = cyc;
            end
        end
        val = '0;
    endtask

    task automatic check_results(input vec_t v, input int dc, input int f, input bit gap);
        check({v.name, "_done"}, (dc >= 0), 1);
        for (int c = 0; c < NC; c++) check({v.name, "_count"}, sent[c], v.n);
        check({v.name, "_error"}, error, v.e_err);
        check({v.name, "_err_chan"}, err_chan, v.e_chan);
        check({v.name, "_err_idx"}, err_idx, v.e_idx);
        check({v.name, "_err_count"}, err_count, v.e_cnt);
        if (v.e_lat != 0) begin
            check({v.name, "_latency"}, dc - f, v.e_lat);
            check({v.name, "_rdy_gap"}, gap, 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        int  dc, dc1, f, diffs, quiet;
        bit  gap;
        vec_t tv;

        reset = 1'b0; start = 1'b0; val = '0; msg = '0; load_en = 1'b0;
        load_chan = '0; load_addr = '0; load_data = '0; max_delay = '0; num_msgs = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_rdy", rdy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_err_count", err_count, 0);

        load_mem();

        //         name            md    n  full poke cmask cidx err chan idx cnt lat
        vecs[0] = '{"full_rate",     8'd0,  4, 1'b1, 1'b1, 2'b00, 0, 0, 0, 0, 0, 4};
        vecs[1] = '{"rand_delay",    8'd10, 4, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{"ch1_idx2_bad",  8'd3,  4, 1'b1, 1'b0, 2'b10, 2, 1, 1, 2, 1, 0};
        vecs[3] = '{"both_idx0_bad", 8'd0,  4, 1'b1, 1'b0, 2'b11, 0, 1, 0, 0, 2, 4};
        vecs[4] = '{"deep_16",       8'd5, 16, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_core(vecs[i], -1, -1, dc, f, gap);
            check_results(vecs[i], dc, f, gap);
        end

        // Rerun from DONE with the same memory: first start only rearms.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("rearm_done_low", done, 0);
        check("rearm_rdy_low", rdy, 0);
        run_core(vecs[1], -1, -1, dc, f, gap);
        check_results(vecs[1], dc, f, gap);

        // num_msgs == 0: done the cycle after start, rdy never raised.
        do_reset();
        num_msgs  = '0;
        max_delay = 8'd3;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("zero_msgs_done", done, 1);
        quiet = (rdy == '0) ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (rdy != '0) quiet = 0;
        end
        check("zero_msgs_rdy_quiet", quiet, 1);

        // Reset mid-run, then rerun: rdy trace must repeat the reference run.
        tv = '{"trace", 8'd7, 16, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0};
        do_reset();
        run_core(tv, 5, -1, dc1, f, gap);
        check_results(tv, dc1, f, gap);
        for (int k = 0; k < TR; k++) trace_ref[k] = trace_now[k];
        do_reset();
        run_core(tv, -1, 12, dc, f, gap);
        do_reset();
        run_core(tv, -1, -1, dc, f, gap);
        check_results(tv, dc, f, gap);
        diffs = 0;
        for (int k = 0; k < TR; k++) if (trace_now[k] !== trace_ref[k]) diffs++;
        check("trace_repeat_diffs", diffs, 0);
        check("trace_repeat_length", dc, dc1);

        check("model_rdy_done_trace", model_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_test_multi_chan_sink.md
VC_TEST_MULTI_CHAN_SINK -- requirements
Module: vc_test_multi_chan_sink

Interface
REQ-001 Parameter p_msg_nbits, default 8, message width per channel.
REQ-002 Parameter p_nchan, default 2, number of independent val/rdy input channels.
REQ-003 Parameter p_max_msgs, default 16, expected-message depth per channel.
REQ-004 Parameter p_lfsr_seed, default 16'hACE1, base LFSR seed.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-low.
REQ-007 max_delay  in  8  maximum random ready-delay in cycles, shared by all channels.
REQ-008 num_msgs  in  clog2(p_max_msgs)+1  messages expected per channel.
REQ-009 load_en  in  1  write strobe for the expected-message memory.
REQ-010 load_chan  in  clog2(p_nchan)  target channel of the write.
REQ-011 load_addr  in  clog2(p_max_msgs)  target index of the write.
REQ-012 load_data  in  p_msg_nbits  expected message.
REQ-013 start  in  1  single-cycle run pulse.
REQ-014 val  in  p_nchan  per-channel valid.
REQ-015 rdy  out  p_nchan  per-channel ready.
REQ-016 msg  in  p_nchan*p_msg_nbits  channel c occupies bits [c*p_msg_nbits +: p_msg_nbits].
REQ-017 done  out  1  all channels have consumed num_msgs messages.
REQ-018 error  out  1  sticky; at least one mismatch seen.
REQ-019 err_chan  out  clog2(p_nchan)  channel of the first mismatch.
REQ-020 err_idx  out  clog2(p_max_msgs)  message index of the first mismatch.
REQ-021 err_count  out  16  total mismatches, saturating at 16'hFFFF.

Function
REQ-022 Each channel SHALL run an FSM with states IDLE, DELAY, WAIT and DONE.
- rdy[c] is 1 only in WAIT.
- done = all channels in DONE.
REQ-023 Loads SHALL be accepted only while every channel is IDLE; otherwise they are ignored.
REQ-024 In IDLE, on start, each channel SHALL go to DONE if num_msgs==0; otherwise it draws a delay d and goes to DELAY (d>0) or WAIT (d==0).
REQ-025 In DELAY, the channel SHALL decrement d each cycle and enter WAIT on the cycle after d reaches 1.
REQ-026 A transfer SHALL occur on a clock edge where val[c] && rdy[c].
- The message is compared with mem[c][idx].
- idx increments.
- Then: if the new idx==num_msgs, go to DONE; else draw a new d and go to DELAY (d>0) or stay in WAIT (d==0).
REQ-027 Delay d SHALL equal the low 8 bits of the channel's 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1) modulo (max_delay+1).
- The LFSR is seeded p_lfsr_seed XOR c and advances every cycle.
- With max_delay==0, rdy SHALL stay high through every transfer (full throughput).
REQ-028 Each mismatch SHALL increment err_count (saturating).
- Multiple mismatches in one cycle add their count.
- error, err_chan and err_idx latch only on the first mismatch; if several channels mismatch simultaneously, the lowest channel wins.
REQ-029 In DONE, rdy SHALL stay 0 and val SHALL be ignored.
- start while any channel is not IDLE SHALL be ignored.
REQ-030 DONE channels SHALL return to IDLE on start only after done is high, permitting reruns with the same memory.

Reset
REQ-031 Asserting reset SHALL immediately return all FSMs to IDLE and clear idx, d, error, err_chan, err_idx and err_count to 0.
- Outputs rdy=0 and done=0.
- LFSRs reload their seeds.
- Memory contents SHALL be retained.
REQ-032 Reset mid-run SHALL abandon the run; no partial transfer is counted.

Structure
REQ-033 Package vc_test_pkg SHALL hold the FSM state enum and the LFSR polynomial and width constants.
REQ-034 Sub-module vc_test_sink_chan SHALL contain one channel's FSM, LFSR, memory and comparator.
- The top generates p_nchan instances.
- The top holds done reduction, error arbitration and err_count.

Verification
REQ-035 p_nchan=2, max_delay=0, num_msgs=4, matching streams with val held high -> rdy constant 1, done 4 cycles after first transfer, err_count=0.
REQ-036 max_delay=10, both sources with random val -> all 4 messages per channel accepted in order, done=1, error=0, run under 5000 cycles.
REQ-037 Channel 1 message 2 = 8'hFF vs expected 8'h03 -> error=1, err_chan=1, err_idx=2, err_count=1, done still reaches 1.
REQ-038 Both channels mismatch at index 0 in the same cycle -> err_chan=0, err_count=2.
REQ-039 num_msgs=0, start -> done=1 next cycle, rdy never asserted.
REQ-040 Reset asserted mid-run, then start -> identical rdy trace to the first run, and memory is not reloaded.
